// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: hold-state encoding and
// default timing for a 12 MHz clock.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } hold_state_t;

  localparam int unsigned DEF_NUM_BTN         = 4;
  localparam logic [3:0]  DEF_ACTIVE_LOW_MASK = 4'b0001;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 120000;
  localparam int unsigned DEF_LONG_CYCLES     = 6000000;

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchroniser, polarity fix, debouncer and hold FSM
// producing a clean level plus registered one-cycle event pulses.
module btn_channel
  import btn_pkg::*;
#(
  parameter logic        ACTIVE_LOW      = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic ev_press,
  output logic ev_release,
  output logic ev_short,
  output logic ev_long
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

  logic          sync1, sync2;
  logic          p_c;
  logic [DW-1:0] dcnt;
  logic          toggle_c, rise_c, fall_c;

  hold_state_t   state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          press_d, release_d, short_d, long_d;

  // Synchroniser idles at the unpressed physical level so reset never looks like a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign p_c      = sync2 ^ ACTIVE_LOW;
  assign toggle_c = (p_c != level) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
  assign rise_c   = toggle_c && !level;
  assign fall_c   = toggle_c && level;

  // Any sample agreeing with the current level restarts the stability count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt  <= '0;
      level <= 1'b0;
    end else begin
      if ((p_c == level) || toggle_c) dcnt <= '0;
      else                            dcnt <= dcnt + DW'(1);
      if (toggle_c) level <= ~level;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hcnt_q     <= '0;
      ev_press   <= 1'b0;
      ev_release <= 1'b0;
      ev_short   <= 1'b0;
      ev_long    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      ev_press   <= press_d;
      ev_release <= release_d;
      ev_short   <= short_d;
      ev_long    <= long_d;
    end
  end

  // Hold FSM; a release on the LONG edge takes priority so the hold counts as short
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_d = HELD;
          hcnt_d  = '0;
          press_d = 1'b1;
        end
      end
      HELD: begin
        if (fall_c) begin
          state_d   = IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
          if (hcnt_q == HW'(LONG_CYCLES - 1)) begin
            state_d = LONG_HELD;
            long_d  = 1'b1;
          end
        end
      end
      LONG_HELD: begin
        if (fall_c) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Array of independent button channels turning raw board pins into clean
// active-high levels and PRESS/RELEASE/SHORT/LONG pulses.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned        NUM_BTN         = DEF_NUM_BTN,
  parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = NUM_BTN'(DEF_ACTIVE_LOW_MASK),
  parameter int unsigned        DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned        LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_BTN-1:0] BTN_RAW,
  output logic [NUM_BTN-1:0] LEVEL,
  output logic [NUM_BTN-1:0] PRESS,
  output logic [NUM_BTN-1:0] RELEASE,
  output logic [NUM_BTN-1:0] SHORT,
  output logic [NUM_BTN-1:0] LONG
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .ACTIVE_LOW     (ACTIVE_LOW_MASK[i]),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk       (CLK),
      .rst_n     (RST_N),
      .raw       (BTN_RAW[i]),
      .level     (LEVEL[i]),
      .ev_press  (PRESS[i]),
      .ev_release(RELEASE[i]),
      .ev_short  (SHORT[i]),
      .ev_long   (LONG[i])
    );
  end

endmodule
